// File: rtl/noc_qos_pkt_scheduler.sv
// Packet-level QoS scheduler for one NoC router output: aged > strict class, round-robin within each, token-bucket rate limiting.
// Latency: req_ready is combinational in the IDLE arbitration cycle; the gnt_* outputs are registered and valid from the next cycle.
// Backpressure: one grant is held until beat_done arrives on its last beat; requests are neither accepted nor arbitrated while BUSY.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_prio/req_len     per-port pending packet (len = beats-1)
//   req_ready                      one-cycle accept pulse to the winner
//   cfg_rate/cfg_burst             per-port token refill per cycle and bucket ceiling
//   beat_done                      crossbar consumed one beat of the granted packet
//   gnt_valid/onehot/idx/prio/aged registered description of the active grant
//   token_count                    bucket levels
//   rate_blocked/cost_err          per-port diagnostics
//   grant_cnt                      saturating count of grants issued
module noc_qos_pkt_scheduler #(
    parameter int NUM_PORTS   = 8,
    parameter int PRIO_WIDTH  = 2,
    parameter int LEN_WIDTH   = 4,
    parameter int TOKEN_WIDTH = 16,
    parameter int AGE_LIMIT   = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS*PRIO_WIDTH-1:0]  req_prio,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0]   req_len,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS*TOKEN_WIDTH-1:0] cfg_rate,
    input  logic [NUM_PORTS*TOKEN_WIDTH-1:0] cfg_burst,
    input  logic                             beat_done,
    output logic                             gnt_valid,
    output logic [NUM_PORTS-1:0]             gnt_onehot,
    output logic [$clog2(NUM_PORTS)-1:0]     gnt_idx,
    output logic [PRIO_WIDTH-1:0]            gnt_prio,
    output logic                             gnt_aged,
    output logic [NUM_PORTS*TOKEN_WIDTH-1:0] token_count,
    output logic [NUM_PORTS-1:0]             rate_blocked,
    output logic [NUM_PORTS-1:0]             cost_err,
    output logic [31:0]                      grant_cnt
);

    localparam int NUM_CLASS = 2 ** PRIO_WIDTH;
    localparam int IDX_W     = $clog2(NUM_PORTS);
    localparam int AGE_W     = $clog2(AGE_LIMIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   beats_left;
    logic [TOKEN_WIDTH-1:0] token    [NUM_PORTS];
    logic [AGE_W-1:0]       wait_cnt [NUM_PORTS];
    logic [IDX_W-1:0]       age_ptr;
    logic [IDX_W-1:0]       cls_ptr  [NUM_CLASS];

    // Unpacked views of the flat per-port buses
    logic [PRIO_WIDTH-1:0]  prio  [NUM_PORTS];
    logic [LEN_WIDTH-1:0]   len   [NUM_PORTS];
    logic [TOKEN_WIDTH-1:0] rate  [NUM_PORTS];
    logic [TOKEN_WIDTH-1:0] burst [NUM_PORTS];
    logic [TOKEN_WIDTH-1:0] cost  [NUM_PORTS];
    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   aged;

    // First set bit of mask at or after ptr, wrapping past NUM_PORTS-1.
    // Callers only use the result when mask is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] mask,
                                                 input logic [IDX_W-1:0]     ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_PORTS);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return idx;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            prio[p]  = req_prio[p*PRIO_WIDTH +: PRIO_WIDTH];
            len[p]   = req_len[p*LEN_WIDTH +: LEN_WIDTH];
            rate[p]  = cfg_rate[p*TOKEN_WIDTH +: TOKEN_WIDTH];
            burst[p] = cfg_burst[p*TOKEN_WIDTH +: TOKEN_WIDTH];
            cost[p]  = TOKEN_WIDTH'(len[p]) + TOKEN_WIDTH'(1);
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p]     = req_valid[p] && (token[p] >= cost[p]);
            aged[p]         = (wait_cnt[p] == AGE_W'(AGE_LIMIT));
            rate_blocked[p] = req_valid[p] && (token[p] < cost[p]);
            cost_err[p]     = req_valid[p] && (cost[p] > burst[p]);
            token_count[p*TOKEN_WIDTH +: TOKEN_WIDTH] = token[p];
        end
    end

    // ---------------- Arbitration ----------------
    logic [NUM_PORTS-1:0]  cls_mask [NUM_CLASS];
    logic [NUM_PORTS-1:0]  aged_elig;
    logic [PRIO_WIDTH-1:0] top_cls;
    logic                  use_age;
    logic                  win_vld;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      win_nxt;

    always_comb begin
        top_cls = '0;
        // Ascending scan so the last non-empty class seen is the highest one
        for (int c = 0; c < NUM_CLASS; c++) begin
            cls_mask[c] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (eligible[p] && (prio[p] == PRIO_WIDTH'(c))) begin
                    cls_mask[c][p] = 1'b1;
                end
            end
            if (|cls_mask[c]) begin
                top_cls = PRIO_WIDTH'(c);
            end
        end

        // Age promotion overrides class order entirely
        aged_elig = aged & eligible;
        use_age   = |aged_elig;
        if (use_age) begin
            win_idx = rr_pick(aged_elig, age_ptr);
        end else begin
            win_idx = rr_pick(cls_mask[top_cls], cls_ptr[top_cls]);
        end
        win_nxt = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);

        win_vld   = (state == IDLE) && (|eligible);
        req_ready = '0;
        if (win_vld) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // ---------------- Token buckets and wait counters ----------------
    logic [TOKEN_WIDTH:0]   tok_sum   [NUM_PORTS];
    logic [TOKEN_WIDTH-1:0] tok_clamp [NUM_PORTS];
    logic [TOKEN_WIDTH-1:0] tok_nxt   [NUM_PORTS];
    logic [AGE_W-1:0]       wait_nxt  [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            // One extra bit so a large refill cannot wrap before the clamp
            tok_sum[p]   = {1'b0, token[p]} + {1'b0, rate[p]};
            tok_clamp[p] = (tok_sum[p] > {1'b0, burst[p]}) ? burst[p]
                                                           : tok_sum[p][TOKEN_WIDTH-1:0];
            tok_nxt[p]   = tok_clamp[p];
            // A burst lowered under cost in the same cycle could make the
            // clamped level smaller than the debit; floor at zero.
            if (req_ready[p]) begin
                tok_nxt[p] = (tok_clamp[p] >= cost[p]) ? tok_clamp[p] - cost[p] : '0;
            end

            if (!req_valid[p] || req_ready[p]) begin
                wait_nxt[p] = '0;
            end else if ((state == BUSY) && gnt_onehot[p]) begin
                wait_nxt[p] = '0;
            end else if (wait_cnt[p] != AGE_W'(AGE_LIMIT)) begin
                wait_nxt[p] = wait_cnt[p] + AGE_W'(1);
            end else begin
                wait_nxt[p] = wait_cnt[p];
            end
        end
    end

    // ---------------- Grant FSM and state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beats_left <= '0;
            age_ptr    <= '0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
            gnt_prio   <= '0;
            gnt_aged   <= 1'b0;
            grant_cnt  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                token[p]    <= '0;
                wait_cnt[p] <= '0;
            end
            for (int c = 0; c < NUM_CLASS; c++) begin
                cls_ptr[c] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                token[p]    <= tok_nxt[p];
                wait_cnt[p] <= wait_nxt[p];
            end

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state      <= BUSY;
                        beats_left <= len[win_idx];
                        gnt_valid  <= 1'b1;
                        gnt_onehot <= req_ready;
                        gnt_idx    <= win_idx;
                        gnt_prio   <= prio[win_idx];
                        gnt_aged   <= use_age;
                        // Only the pointer that produced this winner advances
                        if (use_age) begin
                            age_ptr <= win_nxt;
                        end else begin
                            cls_ptr[top_cls] <= win_nxt;
                        end
                        if (grant_cnt != 32'hFFFF_FFFF) begin
                            grant_cnt <= grant_cnt + 32'd1;
                        end
                    end
                end
                BUSY: begin
                    if (beat_done) begin
                        if (beats_left == '0) begin
                            state      <= IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_onehot <= '0;
                            gnt_idx    <= '0;
                            gnt_prio   <= '0;
                            gnt_aged   <= 1'b0;
                        end else begin
                            beats_left <= beats_left - LEN_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_qos_pkt_scheduler.sv
module tb_noc_qos_pkt_scheduler;

    localparam int NP = 8;
    localparam int PW = 2;
    localparam int LW = 4;
    localparam int TW = 16;
    localparam int AL = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NP-1:0]  req_valid;
    logic [NP*PW-1:0] req_prio;
    logic [NP*LW-1:0] req_len;
    logic [NP-1:0]  req_ready;
    logic [NP*TW-1:0] cfg_rate;
    logic [NP*TW-1:0] cfg_burst;
    logic           beat_done;
    logic           gnt_valid;
    logic [NP-1:0]  gnt_onehot;
    logic [2:0]     gnt_idx;
    logic [PW-1:0]  gnt_prio;
    logic           gnt_aged;
    logic [NP*TW-1:0] token_count;
    logic [NP-1:0]  rate_blocked;
    logic [NP-1:0]  cost_err;
    logic [31:0]    grant_cnt;

    int checks = 0;
    int errors = 0;

    noc_qos_pkt_scheduler #(
        .NUM_PORTS(NP), .PRIO_WIDTH(PW), .LEN_WIDTH(LW), .TOKEN_WIDTH(TW), .AGE_LIMIT(AL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_prio(req_prio), .req_len(req_len), .req_ready(req_ready),
        .cfg_rate(cfg_rate), .cfg_burst(cfg_burst), .beat_done(beat_done),
        .gnt_valid(gnt_valid), .gnt_onehot(gnt_onehot), .gnt_idx(gnt_idx),
        .gnt_prio(gnt_prio), .gnt_aged(gnt_aged), .token_count(token_count),
        .rate_blocked(rate_blocked), .cost_err(cost_err), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Start a new cycle: inputs driven after this are seen by the next edge
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0, the first cycle with rst low
    task automatic do_reset();
        adv();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_prio  = '0;
        req_len   = '0;
        cfg_rate  = '0;
        cfg_burst = '0;
        beat_done = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if ({gnt_onehot, gnt_idx, gnt_prio, gnt_aged} !== '0) begin errors++; $display("FAIL reset_gnt_fields: got %h expected 0", {gnt_onehot, gnt_idx, gnt_prio, gnt_aged}); end
        checks++; if (token_count !== '0) begin errors++; $display("FAIL reset_tokens: got %h expected 0", token_count); end
        checks++; if (grant_cnt !== 32'd0) begin errors++; $display("FAIL reset_grant_cnt: got %0d expected 0", grant_cnt); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
    endtask

    task automatic test_rate_limit();
        logic [NP-1:0] exp_rdy;
        logic          exp_gv;
        clear_inputs();
        beat_done = 1'b1;
        cfg_rate[0 +: TW]  = 16'd1;
        cfg_burst[0 +: TW] = 16'd16;
        req_len[0 +: LW]   = 4'd3;
        req_valid[0]       = 1'b1;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) adv();
            @(negedge clk);
            // Grants at 4, 9, 14, ...; each holds gnt_valid for the next 4 cycles
            exp_rdy = (c >= 4 && ((c - 4) % 5) == 0) ? 8'h01 : 8'h00;
            exp_gv  = (c >= 5 && ((c - 5) % 5) < 4);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rate_req_ready c=%0d: got %h expected %h", c, req_ready, exp_rdy); end
            checks++; if (gnt_valid !== exp_gv) begin errors++; $display("FAIL rate_gnt_valid c=%0d: got %b expected %b", c, gnt_valid, exp_gv); end
            if (c == 0) begin
                checks++; if (rate_blocked !== 8'h01) begin errors++; $display("FAIL rate_blocked_c0: got %h expected 01", rate_blocked); end
            end
            if (c == 4) begin
                checks++; if (token_count[0 +: TW] !== 16'd4) begin errors++; $display("FAIL rate_token_c4: got %0d expected 4", token_count[0 +: TW]); end
            end
            if (c == 5) begin
                checks++; if (token_count[0 +: TW] !== 16'd1) begin errors++; $display("FAIL rate_token_c5: got %0d expected 1", token_count[0 +: TW]); end
                checks++; if (gnt_onehot !== 8'h01 || gnt_idx !== 3'd0) begin errors++; $display("FAIL rate_gnt_port: got %h/%0d expected 01/0", gnt_onehot, gnt_idx); end
            end
            if (c == 9) begin
                checks++; if (token_count[0 +: TW] !== 16'd5) begin errors++; $display("FAIL rate_token_c9: got %0d expected 5", token_count[0 +: TW]); end
            end
            if (c == 30) begin
                checks++; if (grant_cnt !== 32'd6) begin errors++; $display("FAIL rate_grant_cnt: got %0d expected 6", grant_cnt); end
            end
        end
        // Idle port refills up to the burst ceiling and stops there
        req_valid = '0;
        for (int i = 0; i < 20; i++) adv();
        @(negedge clk);
        checks++; if (token_count[0 +: TW] !== 16'd16) begin errors++; $display("FAIL rate_burst_clamp: got %0d expected 16", token_count[0 +: TW]); end
    endtask

    task automatic test_priority_aging();
        logic [NP-1:0] exp_rdy [11];
        exp_rdy = '{8'h02, 8'h00, 8'h08, 8'h00, 8'h20, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h04};
        clear_inputs();
        beat_done = 1'b1;
        for (int p = 0; p < NP; p++) begin
            cfg_rate[p*TW +: TW]  = 16'hFFFF;
            cfg_burst[p*TW +: TW] = 16'hFFFF;
        end
        req_prio[1*PW +: PW] = 2'd3;
        req_prio[3*PW +: PW] = 2'd3;
        req_prio[5*PW +: PW] = 2'd3;
        req_prio[2*PW +: PW] = 2'd0;
        req_prio[4*PW +: PW] = 2'd0;
        do_reset();
        adv();
        adv();
        req_valid = 8'b0010_1110;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) adv();
            // After the aged grant, leave only class-0 ports 2 and 4 so the class-0 pointer is visible
            if (k == 9) req_valid = 8'b0001_0100;
            @(negedge clk);
            checks++; if (req_ready !== exp_rdy[k]) begin errors++; $display("FAIL prio_req_ready k=%0d: got %h expected %h", k, req_ready, exp_rdy[k]); end
            if (k == 1) begin
                checks++; if (gnt_idx !== 3'd1 || gnt_prio !== 2'd3 || gnt_aged !== 1'b0) begin errors++; $display("FAIL prio_first_gnt: got idx %0d prio %0d aged %b expected 1 3 0", gnt_idx, gnt_prio, gnt_aged); end
            end
            if (k == 3) begin
                checks++; if (gnt_idx !== 3'd3) begin errors++; $display("FAIL prio_second_gnt: got %0d expected 3", gnt_idx); end
            end
            if (k == 9) begin
                checks++; if (gnt_onehot !== 8'h04 || gnt_idx !== 3'd2 || gnt_prio !== 2'd0 || gnt_aged !== 1'b1) begin errors++; $display("FAIL aging_gnt: got oh %h idx %0d prio %0d aged %b expected 04 2 0 1", gnt_onehot, gnt_idx, gnt_prio, gnt_aged); end
            end
        end
        adv();
        req_valid = '0;
        @(negedge clk);
        checks++; if (gnt_aged !== 1'b0 || gnt_idx !== 3'd2) begin errors++; $display("FAIL aging_followup_gnt: got idx %0d aged %b expected 2 0", gnt_idx, gnt_aged); end
    endtask

    task automatic test_multi_beat();
        logic exp_gv;
        clear_inputs();
        beat_done = 1'b1;
        for (int p = 0; p < NP; p++) begin
            cfg_rate[p*TW +: TW]  = 16'hFFFF;
            cfg_burst[p*TW +: TW] = 16'hFFFF;
        end
        req_prio[6*PW +: PW] = 2'd2;
        req_len[6*LW +: LW]  = 4'd5;
        req_valid[6]         = 1'b1;
        do_reset();
        @(negedge clk);
        checks++; if (req_ready !== 8'h00 || rate_blocked !== 8'h40) begin errors++; $display("FAIL hold_c0: got rdy %h blk %h expected 00 40", req_ready, rate_blocked); end
        adv();
        @(negedge clk);
        checks++; if (req_ready !== 8'h40) begin errors++; $display("FAIL hold_grant: got %h expected 40", req_ready); end
        adv();
        req_valid = '0;
        // beat_done on even steps: 6th pulse at i=10, so gnt_valid drops at i=11
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) adv();
            beat_done = ((i % 2) == 0);
            @(negedge clk);
            exp_gv = (i <= 10);
            checks++; if (gnt_valid !== exp_gv) begin errors++; $display("FAIL hold_gnt_valid i=%0d: got %b expected %b", i, gnt_valid, exp_gv); end
            if (i <= 10) begin
                checks++; if (gnt_onehot !== 8'h40 || gnt_idx !== 3'd6 || gnt_prio !== 2'd2) begin errors++; $display("FAIL hold_gnt_stable i=%0d: got %h/%0d/%0d expected 40/6/2", i, gnt_onehot, gnt_idx, gnt_prio); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            adv();
            beat_done = 1'b1;
            @(negedge clk);
            checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL idle_beat_done i=%0d: got %b expected 0", i, gnt_valid); end
        end
        checks++; if (grant_cnt !== 32'd1) begin errors++; $display("FAIL idle_grant_cnt: got %0d expected 1", grant_cnt); end
    endtask

    task automatic test_boundaries();
        // Saturation and burst lowering (class-2 pointer sits at 7 after the multi-beat grant)
        adv();
        cfg_burst[3*TW +: TW] = 16'd8;
        @(negedge clk);
        checks++; if (token_count[5*TW +: TW] !== 16'hFFFF) begin errors++; $display("FAIL token_saturate: got %h expected ffff", token_count[5*TW +: TW]); end
        checks++; if (token_count[3*TW +: TW] !== 16'hFFFF) begin errors++; $display("FAIL burst_lower_same_cycle: got %h expected ffff", token_count[3*TW +: TW]); end
        adv();
        req_valid[3]        = 1'b1;
        req_len[3*LW +: LW] = 4'd15;
        @(negedge clk);
        checks++; if (token_count[3*TW +: TW] !== 16'd8) begin errors++; $display("FAIL burst_lower_next_cycle: got %0d expected 8", token_count[3*TW +: TW]); end
        checks++; if (cost_err !== 8'h08) begin errors++; $display("FAIL cost_err: got %h expected 08", cost_err); end
        checks++; if (rate_blocked !== 8'h08 || req_ready !== 8'h00) begin errors++; $display("FAIL cost_err_no_grant: got blk %h rdy %h expected 08 00", rate_blocked, req_ready); end
        adv();
        req_valid            = 8'h81;
        req_len              = '0;
        req_prio[7*PW +: PW] = 2'd2;
        req_prio[0*PW +: PW] = 2'd2;
        beat_done            = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 8'h80) begin errors++; $display("FAIL wrap_first: got %h expected 80", req_ready); end
        adv();
        @(negedge clk);
        checks++; if (req_ready !== 8'h00 || gnt_idx !== 3'd7) begin errors++; $display("FAIL wrap_busy: got rdy %h idx %0d expected 00 7", req_ready, gnt_idx); end
        adv();
        @(negedge clk);
        checks++; if (req_ready !== 8'h01) begin errors++; $display("FAIL wrap_second: got %h expected 01", req_ready); end
        adv();
        req_valid = '0;
    endtask

    task automatic test_reset_mid_packet();
        logic [NP-1:0] exp_rdy;
        clear_inputs();
        cfg_rate[0 +: TW]  = 16'd1;
        cfg_burst[0 +: TW] = 16'd16;
        req_len[0 +: LW]   = 4'd3;
        req_valid[0]       = 1'b1;
        do_reset();
        for (int c = 1; c <= 6; c++) adv();
        @(negedge clk);
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL midpkt_busy: got %b expected 1", gnt_valid); end
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (gnt_valid !== 1'b0 || gnt_onehot !== '0 || gnt_idx !== '0) begin errors++; $display("FAIL midpkt_gnt_cleared: got %b %h %0d expected 0 00 0", gnt_valid, gnt_onehot, gnt_idx); end
        checks++; if (token_count !== '0 || grant_cnt !== 32'd0 || req_ready !== '0) begin errors++; $display("FAIL midpkt_state_cleared: got tok %h cnt %0d rdy %h expected 0 0 0", token_count, grant_cnt, req_ready); end
        for (int c = 1; c <= 4; c++) begin
            adv();
            @(negedge clk);
            exp_rdy = (c == 4) ? 8'h01 : 8'h00;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL midpkt_regrant c=%0d: got %h expected %h", c, req_ready, exp_rdy); end
        end
    endtask

    initial begin
        test_reset();
        test_rate_limit();
        test_priority_aging();
        test_multi_beat();
        test_boundaries();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
